// File: rtl/mux_scan_reg.sv
// Registered N-to-1 channel mux with a valid/ready output stage.
// Direct mode forwards the selected channel; scan mode sweeps all channels in order.
module mux_scan_reg #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned N     = 32,
   parameter int unsigned SELW  = $clog2(N)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [N*WIDTH-1:0] data_in,
   input  logic               mode,
   input  logic [SELW-1:0]    sel,
   input  logic               in_valid,
   input  logic               out_ready,
   output logic               out_valid,
   output logic [WIDTH-1:0]   out_data,
   output logic [SELW-1:0]    out_sel,
   output logic               scan_wrap
);

   localparam logic [SELW-1:0] LastIdx = SELW'(N - 1);

   logic             mode_q;
   logic [SELW-1:0]  cnt_q, cnt_d;
   logic [SELW-1:0]  cnt_eff;
   logic [SELW-1:0]  idx;
   logic [WIDTH-1:0] chan;
   logic             accept;
   logic             scan_entry;
   logic             at_last;

   assign accept     = in_valid && (!out_valid || out_ready);
   assign scan_entry = mode && !mode_q;
   // A fresh scan always starts at channel 0, even if the counter holds a stale value.
   assign cnt_eff    = scan_entry ? '0 : cnt_q;
   assign at_last    = (cnt_eff == LastIdx);
   assign idx        = mode ? cnt_eff : sel;

   // Out-of-range direct selects fall through to zero.
   always_comb begin
      chan = '0;
      for (int i = 0; i < int'(N); i++) begin
         if (idx == SELW'(i)) chan = data_in[i*WIDTH +: WIDTH];
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (scan_entry) cnt_d = '0;
      if (accept && mode) cnt_d = at_last ? '0 : cnt_eff + 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
         scan_wrap <= 1'b0;
         cnt_q     <= '0;
         mode_q    <= 1'b0;
      end else begin
         mode_q <= mode;
         cnt_q  <= cnt_d;
         if (accept) begin
            out_valid <= 1'b1;
            out_data  <= chan;
            out_sel   <= idx;
            scan_wrap <= mode && at_last;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
